// File: rtl/axis_tx_pkg.sv
// Shared definitions for the AXI4-Stream frame transmitter.
// The per-module entry struct lives in the top because its data width is a
// module parameter; this package only holds width-independent items.
package axis_tx_pkg;

  // Width of the optional statistics counters.
  localparam int STATS_W = 16;

  // Output dimension of a valid-kernel crop: dim-(kernel-1), or 0 when the
  // image is too small to produce any output pixel.
  function automatic logic [31:0] crop_dim(input logic [31:0] dim,
                                           input logic [31:0] kernel);
    logic [31:0] margin;
    margin = kernel - 32'd1;
    if (dim > margin) begin
      return dim - margin;
    end else begin
      return 32'd0;
    end
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Generic synchronous first-word-fall-through FIFO.
// Writes always land in the storage array; the head register is reloaded
// from storage on the following edge, so a word written into an empty FIFO
// becomes visible one cycle after its write. o_count covers storage plus
// head. A write while full is refused unless the head leaves the same cycle.
module sync_fifo_fwft #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_rd_ready,
  output logic                       o_rd_valid,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_almost_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    mem_cnt_q, mem_cnt_d;
  logic [CW-1:0]    count_q, count_d;
  logic             head_valid_q, head_valid_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             almost_full_q, almost_full_d;
  logic             full_s, rd_fire_s, wr_accept_s, load_head_s;

  // Next-state for pointers, occupancy and the registered head.
  always_comb begin
    full_s      = (count_q == CW'(DEPTH));
    rd_fire_s   = head_valid_q && i_rd_ready;
    wr_accept_s = i_wr_en && (!full_s || rd_fire_s);
    load_head_s = (mem_cnt_q != '0) && (!head_valid_q || rd_fire_s);

    head_valid_d = head_valid_q;
    head_d       = head_q;
    if (load_head_s) begin
      head_valid_d = 1'b1;
      head_d       = mem_q[rd_ptr_q];
    end else if (rd_fire_s) begin
      head_valid_d = 1'b0;
    end else begin
      head_valid_d = head_valid_q;
    end

    wr_ptr_d      = wr_ptr_q + AW'(wr_accept_s);
    rd_ptr_d      = rd_ptr_q + AW'(load_head_s);
    mem_cnt_d     = mem_cnt_q + CW'(wr_accept_s) - CW'(load_head_s);
    count_d       = mem_cnt_d + CW'(head_valid_d);
    almost_full_d = (count_d >= CW'(AF_LEVEL));
  end

  // Storage array; no reset needed since the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (wr_accept_s) begin
      mem_q[wr_ptr_q] <= i_wr_data;
    end
  end

  // Control and head registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mem_cnt_q     <= '0;
      count_q       <= '0;
      head_valid_q  <= 1'b0;
      head_q        <= '0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_cnt_q     <= mem_cnt_d;
      count_q       <= count_d;
      head_valid_q  <= head_valid_d;
      head_q        <= head_d;
      almost_full_q <= almost_full_d;
    end
  end

  assign o_rd_valid    = head_valid_q;
  assign o_rd_data     = head_q;
  assign o_count       = count_q;
  assign o_almost_full = almost_full_q;

endmodule

// File: rtl/axis_frame_tx_fifo.sv
// AXI4-Stream frame transmitter: crops the processing stream to the
// valid-kernel output size, tags tuser/tlast from runtime dimensions and
// buffers words in an FWFT FIFO so m_axis_tready backpressure is honoured.
// Optional statistics ports are enabled with the macro AXIS_TX_STATS_EN.
module axis_frame_tx_fifo
  import axis_tx_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int DIM_WIDTH   = 13,
  parameter int KERNEL_SIZE = 5
) (
  input  logic                  i_clk,
  input  logic                  i_aresetn,
  input  logic [DIM_WIDTH-1:0]  IMG_WIDTH,
  input  logic [DIM_WIDTH-1:0]  IMG_HEIGHT,
  input  logic [DATA_WIDTH-1:0] i_pixel,
  input  logic                  i_pixel_valid,
  input  logic                  i_start_of_frame,
  input  logic                  i_clear,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  o_almost_full,
  output logic                  o_overflow,
  output logic                  o_sof_err
`ifdef AXIS_TX_STATS_EN
  ,
  output logic [STATS_W-1:0]    o_frame_count,
  output logic [STATS_W-1:0]    o_drop_count
`endif
);

  typedef struct packed {
    logic                  tuser;
    logic                  tlast;
    logic [DATA_WIDTH-1:0] data;
  } tx_entry_t;

  localparam int ENTRY_W = $bits(tx_entry_t);
`ifdef AXIS_TX_STATS_EN
  // One extra bit travels with each word to mark the end of a frame.
  localparam int FIFO_W = ENTRY_W + 1;
`else
  localparam int FIFO_W = ENTRY_W;
`endif
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                 started_q, started_d;
  logic [DIM_WIDTH-1:0] out_w_q, out_w_d;
  logic [DIM_WIDTH-1:0] out_h_q, out_h_d;
  logic [DIM_WIDTH-1:0] col_q, col_d;
  logic [DIM_WIDTH-1:0] row_q, row_d;
  logic                 overflow_q, overflow_d;
  logic                 sof_err_q, sof_err_d;

  logic                 sof_s, empty_frame_s, wr_en_s, eof_s, drop_s;
  logic [DIM_WIDTH-1:0] crop_w_s, crop_h_s, eff_w_s, eff_h_s;
  logic [DIM_WIDTH-1:0] col_cur_s, row_cur_s;
  tx_entry_t            wr_entry_s, head_entry_s;
  logic [FIFO_W-1:0]    fifo_wr_data_s, fifo_rd_data_s;
  logic                 fifo_valid_s, fifo_almost_full_s, read_fire_s;
  logic [CW-1:0]        fifo_count_s;

  // Position tracking, tagging and write request for the incoming pixel.
  always_comb begin
    sof_s    = i_pixel_valid && i_start_of_frame;
    crop_w_s = DIM_WIDTH'(crop_dim(32'(IMG_WIDTH), 32'(KERNEL_SIZE)));
    crop_h_s = DIM_WIDTH'(crop_dim(32'(IMG_HEIGHT), 32'(KERNEL_SIZE)));

    started_d = started_q;
    out_w_d   = out_w_q;
    out_h_d   = out_h_q;
    if (sof_s) begin
      started_d = 1'b1;
      out_w_d   = crop_w_s;
      out_h_d   = crop_h_s;
      eff_w_s   = crop_w_s;
      eff_h_s   = crop_h_s;
      col_cur_s = '0;
      row_cur_s = '0;
    end else begin
      eff_w_s   = out_w_q;
      eff_h_s   = out_h_q;
      col_cur_s = col_q;
      row_cur_s = row_q;
    end

    empty_frame_s = (eff_w_s == '0) || (eff_h_s == '0);

    wr_en_s          = 1'b0;
    wr_entry_s.tuser = (col_cur_s == '0) && (row_cur_s == '0);
    wr_entry_s.tlast = (col_cur_s == (eff_w_s - DIM_WIDTH'(1)));
    wr_entry_s.data  = i_pixel;
    eof_s            = wr_entry_s.tlast && (row_cur_s == (eff_h_s - DIM_WIDTH'(1)));
    col_d            = col_cur_s;
    row_d            = row_cur_s;

    if (i_pixel_valid && (started_q || sof_s) && !empty_frame_s) begin
      wr_en_s = 1'b1;
      if (wr_entry_s.tlast) begin
        col_d = '0;
        if (row_cur_s == (eff_h_s - DIM_WIDTH'(1))) begin
          row_d = '0;
        end else begin
          row_d = row_cur_s + DIM_WIDTH'(1);
        end
      end else begin
        col_d = col_cur_s + DIM_WIDTH'(1);
        row_d = row_cur_s;
      end
    end else begin
      wr_en_s = 1'b0;
    end

    sof_err_d = sof_s && ((col_q != '0) || (row_q != '0));
  end

  // Drop detection and the sticky overflow flag; a new drop beats a clear.
  always_comb begin
    read_fire_s = fifo_valid_s && m_axis_tready;
    drop_s      = wr_en_s && (fifo_count_s == CW'(FIFO_DEPTH)) && !read_fire_s;
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (i_clear) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

`ifdef AXIS_TX_STATS_EN
  assign fifo_wr_data_s = {eof_s, wr_entry_s};
`else
  assign fifo_wr_data_s = wr_entry_s;
`endif

  sync_fifo_fwft #(
    .WIDTH    (FIFO_W),
    .DEPTH    (FIFO_DEPTH),
    .AF_LEVEL (FIFO_DEPTH - 2)
  ) u_fifo (
    .i_clk         (i_clk),
    .i_rst_n       (i_aresetn),
    .i_wr_en       (wr_en_s),
    .i_wr_data     (fifo_wr_data_s),
    .i_rd_ready    (m_axis_tready),
    .o_rd_valid    (fifo_valid_s),
    .o_rd_data     (fifo_rd_data_s),
    .o_count       (fifo_count_s),
    .o_almost_full (fifo_almost_full_s)
  );

  // Frame position, latched dimensions and status flags.
  always_ff @(posedge i_clk) begin
    if (!i_aresetn) begin
      started_q  <= 1'b0;
      out_w_q    <= '0;
      out_h_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      overflow_q <= 1'b0;
      sof_err_q  <= 1'b0;
    end else begin
      started_q  <= started_d;
      out_w_q    <= out_w_d;
      out_h_q    <= out_h_d;
      col_q      <= col_d;
      row_q      <= row_d;
      overflow_q <= overflow_d;
      sof_err_q  <= sof_err_d;
    end
  end

  assign head_entry_s  = tx_entry_t'(fifo_rd_data_s[ENTRY_W-1:0]);
  assign m_axis_tvalid = fifo_valid_s;
  assign m_axis_tdata  = head_entry_s.data;
  assign m_axis_tuser  = head_entry_s.tuser;
  assign m_axis_tlast  = head_entry_s.tlast;
  assign o_almost_full = fifo_almost_full_s;
  assign o_overflow    = overflow_q;
  assign o_sof_err     = sof_err_q;

`ifdef AXIS_TX_STATS_EN
  logic [STATS_W-1:0] frame_count_q, frame_count_d;
  logic [STATS_W-1:0] drop_count_q, drop_count_d;

  // Frame counter wraps; drop counter saturates and is cleared by i_clear.
  always_comb begin
    if (read_fire_s && fifo_rd_data_s[FIFO_W-1]) begin
      frame_count_d = frame_count_q + STATS_W'(1);
    end else begin
      frame_count_d = frame_count_q;
    end
    if (i_clear) begin
      drop_count_d = STATS_W'(drop_s);
    end else if (drop_s && (drop_count_q != {STATS_W{1'b1}})) begin
      drop_count_d = drop_count_q + STATS_W'(1);
    end else begin
      drop_count_d = drop_count_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge i_clk) begin
    if (!i_aresetn) begin
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign o_frame_count = frame_count_q;
  assign o_drop_count  = drop_count_q;
`endif

endmodule

// File: tb/tb_axis_frame_tx_fifo.sv
// Self-checking bench for axis_frame_tx_fifo (FIFO_DEPTH=4 to reach full
// quickly). The reference model tracks a frame pixel index and a queue of
// expected words stamped with their write cycle.
module tb_axis_frame_tx_fifo;

  localparam int DW = 32;
  localparam int D  = 4;
  localparam int DIMW = 13;
  localparam int K  = 5;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [DIMW-1:0] img_w = 13'd8;
  logic [DIMW-1:0] img_h = 13'd6;
  logic [DW-1:0]   pixel = 32'd0;
  logic            pv = 1'b0;
  logic            sof = 1'b0;
  logic            clr = 1'b0;
  logic            tready = 1'b0;
  logic [DW-1:0]   tdata;
  logic            tvalid, tuser, tlast, af, ovf_o, sof_err_o;
`ifdef AXIS_TX_STATS_EN
  logic [15:0]     frame_cnt_o, drop_cnt_o;
`endif

  always #5 clk = ~clk;

  axis_frame_tx_fifo #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(D), .DIM_WIDTH(DIMW), .KERNEL_SIZE(K)
  ) dut (
    .i_clk(clk), .i_aresetn(rstn), .IMG_WIDTH(img_w), .IMG_HEIGHT(img_h),
    .i_pixel(pixel), .i_pixel_valid(pv), .i_start_of_frame(sof),
    .i_clear(clr), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tuser(tuser), .m_axis_tlast(tlast),
    .o_almost_full(af), .o_overflow(ovf_o), .o_sof_err(sof_err_o)
`ifdef AXIS_TX_STATS_EN
    , .o_frame_count(frame_cnt_o), .o_drop_count(drop_cnt_o)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          user;
    logic          last;
    logic          eof;
    int            wedge;
  } exp_t;

  exp_t q[$];
  int   edge_no = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   started = 0;
  int   idx = 0, ow = 0, oh = 0;
  bit   m_ovf = 0, m_sof_err = 0, mtv = 0;
  int   m_frames = 0, m_drops = 0;

  function automatic int crop(input int dim);
    return (dim > K - 1) ? dim - (K - 1) : 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then
  // compare every output 1 time unit later.
  task automatic step();
    exp_t e;
    bit   rd, drop, wr;
    @(posedge clk);
    edge_no++;
    if (!rstn) begin
      q.delete();
      started = 0; idx = 0; m_ovf = 0; m_sof_err = 0; m_frames = 0; m_drops = 0;
    end else begin
      rd = mtv && tready;
      drop = 0; wr = 0;
      m_sof_err = pv && sof && (idx != 0);
      if (pv && sof) begin
        started = 1; ow = crop(int'(img_w)); oh = crop(int'(img_h)); idx = 0;
      end
      if (pv && started && ow > 0 && oh > 0) begin
        e.data = pixel;
        e.user = (idx == 0);
        e.last = ((idx % ow) == ow - 1);
        e.eof  = e.last && ((idx / ow) == oh - 1);
        e.wedge = edge_no;
        idx = (idx + 1) % (ow * oh);
        wr = 1;
        if (q.size() == D && !rd) drop = 1;
      end
      if (rd) begin
        if (q[0].eof) m_frames = (m_frames + 1) % 65536;
        void'(q.pop_front());
      end
      if (wr && !drop) q.push_back(e);
      if (drop) m_ovf = 1; else if (clr) m_ovf = 0;
      if (clr) m_drops = drop ? 1 : 0;
      else if (drop && m_drops < 65535) m_drops++;
    end
    mtv = (q.size() > 0) && (q[0].wedge < edge_no);
    #1;
    chk("tvalid", 64'(tvalid), 64'(mtv));
    if (mtv) begin
      chk("tdata", 64'(tdata), 64'(q[0].data));
      chk("tuser", 64'(tuser), 64'(q[0].user));
      chk("tlast", 64'(tlast), 64'(q[0].last));
    end
    chk("almost_full", 64'(af), 64'(q.size() >= D - 2));
    chk("overflow", 64'(ovf_o), 64'(m_ovf));
    chk("sof_err", 64'(sof_err_o), 64'(m_sof_err));
`ifdef AXIS_TX_STATS_EN
    chk("frame_count", 64'(frame_cnt_o), 64'(m_frames));
    chk("drop_count", 64'(drop_cnt_o), 64'(m_drops));
`endif
  endtask

  task automatic drive(input bit v, input bit s, input logic [DW-1:0] p, input bit r);
    pv = v; sof = s; pixel = p; tready = r;
    step();
  endtask

  initial begin
    // Reset: all outputs zero.
    rstn = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("reset_tdata", 64'(tdata), 64'd0);
    chk("reset_tuser", 64'(tuser), 64'd0);
    chk("reset_tlast", 64'(tlast), 64'd0);
    rstn = 1'b1;

    // Pixels before the first SOF are silently dropped.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 32'(100 + i), 1'b1);

    // 8x6 image, K=5 -> 4x2 output; 8 contiguous pixels with tready=1.
    img_w = 13'd8; img_h = 13'd6;
    for (int i = 0; i < 8; i++) drive(1'b1, (i == 0), 32'(i), 1'b1);
    repeat (3) drive(1'b0, 1'b0, 32'd0, 1'b1);

    // Stalled output: 6 pixels into a 4-deep FIFO -> 2 drops, sticky overflow.
    for (int i = 0; i < 6; i++) drive(1'b1, (i == 0), 32'(16 + i), 1'b0);
    repeat (2) drive(1'b0, 1'b0, 32'd0, 1'b0);
    repeat (6) drive(1'b0, 1'b0, 32'd0, 1'b1);
    clr = 1'b1; drive(1'b0, 1'b0, 32'd0, 1'b1); clr = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 1'b1);

    // Fill the FIFO, then write while reading each cycle: no drop.
    for (int i = 0; i < 4; i++) drive(1'b1, (i == 0), 32'(32 + i), 1'b0);
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 4; i < 8; i++) drive(1'b1, 1'b0, 32'(32 + i), 1'b1);
    repeat (6) drive(1'b0, 1'b0, 32'd0, 1'b1);

    // SOF arriving at pixel 2 of a frame: error pulse, counting restarts.
    for (int i = 0; i < 2; i++) drive(1'b1, (i == 0), 32'(48 + i), 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b1, (i == 0), 32'(64 + i), 1'b1);
    repeat (4) drive(1'b0, 1'b0, 32'd0, 1'b1);

    // Reset with 3 words buffered, then a clean frame.
    for (int i = 0; i < 3; i++) drive(1'b1, (i == 0), 32'(80 + i), 1'b0);
    rstn = 1'b0; drive(1'b0, 1'b0, 32'd0, 1'b0); rstn = 1'b1;
    drive(1'b1, 1'b0, 32'd99, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b1, (i == 0), 32'(96 + i), 1'b1);
    repeat (3) drive(1'b0, 1'b0, 32'd0, 1'b1);

    // tready toggling 1010..., 16 pixels on alternate cycles.
    for (int i = 0; i < 32; i++)
      drive((i % 2) == 0, (i == 0), 32'(128 + i / 2), (i % 2) == 0);
    repeat (6) drive(1'b0, 1'b0, 32'd0, 1'b1);

    // Empty output frame (3x3 image): all pixels dropped, no overflow.
    img_w = 13'd3; img_h = 13'd3;
    for (int i = 0; i < 6; i++) drive(1'b1, (i == 0), 32'(200 + i), 1'b0);
    drive(1'b0, 1'b0, 32'd0, 1'b1);

    // Randomised traffic with random dimensions, SOFs, stalls and clears.
    for (int i = 0; i < 600; i++) begin
      img_w = 13'($urandom_range(9, 3));
      img_h = 13'($urandom_range(7, 3));
      clr = ($urandom_range(49, 0) == 0);
      drive(($urandom_range(9, 0) < 7), ($urandom_range(14, 0) == 0),
            32'($urandom), ($urandom_range(9, 0) < 6));
    end
    clr = 1'b0;
    repeat (10) drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("drained", 64'(tvalid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
